// File: rtl/tmr_shift_reg_scrub_if.sv
// rtl/tmr_shift_reg_scrub_if.sv - Control, data and status bundle for the TMR scrubbing shift register
//
// Purpose: groups every non-clock/reset signal of tmr_shift_reg_scrub.
// The master modport drives the controls and reads the status. The slave modport is the register side.
// Signals:
//   enable, load, mode[2:0]   update enable, parallel-load select, shift mode
//   serial_in, parallel_in    shift/load data
//   clr_status                pulse clearing health, counters and sticky flag
//   inj_valid/inj_sel/mask    fault injection: XOR mask onto replica inj_sel
//   parallel_out, serial_out  voted data
//   health, err_cnt           per-replica status {r2,r1,r0}
//   uncorrectable             sticky duplex disagreement flag
//   scrub_active              scrub tick applied at the end of this cycle
interface tmr_shift_reg_scrub_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 4
);
  logic                   enable;
  logic                   load;
  logic [2:0]             mode;
  logic                   serial_in;
  logic [WIDTH-1:0]       parallel_in;
  logic                   clr_status;
  logic                   inj_valid;
  logic [1:0]             inj_sel;
  logic [WIDTH-1:0]       inj_mask;
  logic [WIDTH-1:0]       parallel_out;
  logic                   serial_out;
  logic [5:0]             health;
  logic [3*ERR_CNT_W-1:0] err_cnt;
  logic                   uncorrectable;
  logic                   scrub_active;

  modport master (
    output enable, load, mode, serial_in, parallel_in, clr_status,
           inj_valid, inj_sel, inj_mask,
    input  parallel_out, serial_out, health, err_cnt, uncorrectable, scrub_active
  );

  modport slave (
    input  enable, load, mode, serial_in, parallel_in, clr_status,
           inj_valid, inj_sel, inj_mask,
    output parallel_out, serial_out, health, err_cnt, uncorrectable, scrub_active
  );
endinterface

// File: rtl/tmr_shift_reg_scrub.sv
// rtl/tmr_shift_reg_scrub.sv - Triple-redundant universal shift register with voting, health tracking and idle scrubbing
//
// Purpose: three replicas of a universal shift register (SISO-R/L, PISO, PIPO, ROT-R/L, hold).
// A combinational voter produces the output.
// Replicas that disagree with a full triple vote are corrected on every update event and counted.
// Replicas that repeatedly disagree are excluded as FAILED, so voting degrades to duplex and then simplex.
// While enable stays low, a periodic scrub tick corrects the replicas.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  tmr_shift_reg_scrub_if.slave (controls in, voted data and status out)
module tmr_shift_reg_scrub #(
  parameter int WIDTH        = 8,
  parameter int ERR_CNT_W    = 4,
  parameter int FAIL_THRESH  = 3,
  parameter int SCRUB_PERIOD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  tmr_shift_reg_scrub_if.slave  bus
);
  localparam int CON_W = $clog2(FAIL_THRESH + 1);
  localparam int SCR_W = $clog2(SCRUB_PERIOD);
  localparam logic [CON_W-1:0] CON_MAX = CON_W'(FAIL_THRESH);

  typedef enum logic [1:0] {
    HEALTHY = 2'b00,
    SUSPECT = 2'b01,
    FAILED  = 2'b10
  } health_t;

  logic [WIDTH-1:0]     r_rep    [3];
  health_t              r_health [3];
  logic [CON_W-1:0]     r_consec [3];
  logic [ERR_CNT_W-1:0] r_err    [3];
  logic                 r_uncorr;
  logic [SCR_W-1:0]     r_scrub_cnt;

  logic [2:0]       w_ok;
  logic [1:0]       w_num_ok;
  logic [1:0]       w_sel;
  logic [WIDTH-1:0] w_vote;
  logic [2:0]       w_sbit;
  logic             w_sout;
  logic [2:0]       w_mism;
  logic [2:0]       w_want_fail;
  logic [2:0]       w_do_fail;
  logic             w_dup_diff;
  logic             w_tick;
  logic             w_upd;
  logic [WIDTH-1:0] w_base   [3];
  logic [WIDTH-1:0] w_next   [3];

  function automatic logic [WIDTH-1:0] shift_next(
    input logic [2:0]       m,
    input logic             ld,
    input logic             sin,
    input logic [WIDTH-1:0] pin,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (m)
      3'd0:    r = {sin, b[WIDTH-1:1]};
      3'd1:    r = {b[WIDTH-2:0], sin};
      3'd2:    r = ld ? pin : {1'b0, b[WIDTH-1:1]};
      3'd3:    r = ld ? pin : b;
      3'd4:    r = {b[0], b[WIDTH-1:1]};
      3'd5:    r = {b[WIDTH-2:0], b[WIDTH-1]};
      default: r = b;
    endcase
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_ok[i] = (r_health[i] != FAILED);
    end
    w_num_ok = {1'b0, w_ok[0]} + {1'b0, w_ok[1]} + {1'b0, w_ok[2]};
    // Lowest-index live replica drives the output in duplex/simplex.
    w_sel = w_ok[0] ? 2'd0 : (w_ok[1] ? 2'd1 : 2'd2);

    for (int i = 0; i < 3; i++) begin
      w_sbit[i] = (bus.mode == 3'd0 || bus.mode == 3'd2 || bus.mode == 3'd4)
                  ? r_rep[i][0] : r_rep[i][WIDTH-1];
    end

    if (w_num_ok == 2'd3) begin
      w_vote = (r_rep[0] & r_rep[1]) | (r_rep[0] & r_rep[2]) | (r_rep[1] & r_rep[2]);
      w_sout = (w_sbit[0] & w_sbit[1]) | (w_sbit[0] & w_sbit[2]) | (w_sbit[1] & w_sbit[2]);
    end else begin
      w_vote = r_rep[w_sel];
      w_sout = w_sbit[w_sel];
    end

    w_dup_diff = (w_ok == 3'b011 && r_rep[0] != r_rep[1]) ||
                 (w_ok == 3'b101 && r_rep[0] != r_rep[2]) ||
                 (w_ok == 3'b110 && r_rep[1] != r_rep[2]);

    w_tick = !bus.enable && (r_scrub_cnt == SCR_W'(SCRUB_PERIOD - 1));
    w_upd  = bus.enable || w_tick;

    for (int i = 0; i < 3; i++) begin
      // Blame is only assigned when a true majority exists.
      w_mism[i]      = (w_num_ok == 2'd3) && (r_rep[i] != w_vote);
      w_want_fail[i] = w_mism[i] && (r_consec[i] >= CON_W'(FAIL_THRESH - 1));
      w_base[i]      = w_mism[i] ? w_vote : r_rep[i];
      if (bus.enable) begin
        w_next[i] = shift_next(bus.mode, bus.load, bus.serial_in, bus.parallel_in, w_base[i]);
      end else if (w_tick) begin
        w_next[i] = w_base[i];
      end else begin
        w_next[i] = r_rep[i];
      end
      if (bus.inj_valid && bus.inj_sel == i[1:0]) begin
        w_next[i] = w_next[i] ^ bus.inj_mask;
      end
    end
    // If all three would fail together, replica 0 survives as the last voter.
    w_do_fail = (&w_want_fail) ? (w_want_fail & 3'b110) : w_want_fail;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        r_rep[i]    <= '0;
        r_health[i] <= HEALTHY;
        r_consec[i] <= '0;
        r_err[i]    <= '0;
      end
      r_uncorr    <= 1'b0;
      r_scrub_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_rep[i] <= w_next[i];
        if (bus.clr_status) begin
          r_health[i] <= HEALTHY;
          r_consec[i] <= '0;
          r_err[i]    <= '0;
        end else if (w_upd && w_num_ok == 2'd3) begin
          if (w_mism[i]) begin
            if (r_err[i] != '1) r_err[i] <= r_err[i] + 1'b1;
            if (r_consec[i] != CON_MAX) r_consec[i] <= r_consec[i] + 1'b1;
            r_health[i] <= w_do_fail[i] ? FAILED : SUSPECT;
          end else begin
            r_health[i] <= HEALTHY;
            r_consec[i] <= '0;
          end
        end
      end

      if (bus.clr_status) begin
        r_uncorr <= 1'b0;
      end else if (w_dup_diff) begin
        r_uncorr <= 1'b1;
      end

      if (w_upd) begin
        r_scrub_cnt <= '0;
      end else begin
        r_scrub_cnt <= r_scrub_cnt + 1'b1;
      end
    end
  end

  assign bus.parallel_out  = w_vote;
  assign bus.serial_out    = w_sout;
  assign bus.health        = {r_health[2], r_health[1], r_health[0]};
  assign bus.err_cnt       = {r_err[2], r_err[1], r_err[0]};
  assign bus.uncorrectable = r_uncorr;
  assign bus.scrub_active  = w_tick;
endmodule

// File: doc/tmr_shift_reg_scrub.md
Name: tmr_shift_reg_scrub

Overview:
Triple-modular-redundant universal shift register with a majority voter and per-replica health tracking. It extends the team's TMR register family in four ways:
- rotate modes
- periodic background scrubbing while idle
- saturating per-replica error counters with FAILED exclusion (degrades to duplex/simplex voting)
- a fault-injection port for bench controllability

It sits wherever a hardened data/shift register is needed in radiation-tolerant datapaths.

Parameters:
WIDTH, 8, data width of each replica (>=2)
ERR_CNT_W, 4, width of each per-replica saturating correction counter
FAIL_THRESH, 3, consecutive mismatching updates before a replica is marked FAILED (>=1)
SCRUB_PERIOD, 16, idle cycles between scrub ticks (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
enable  in  1  shift/load update enable
load  in  1  parallel load select (modes PISO, PIPO)
mode  in  3  0 SISO-R, 1 SISO-L, 2 PISO, 3 PIPO, 4 ROT-R, 5 ROT-L, 6/7 hold
serial_in  in  1  serial data input
parallel_in  in  WIDTH  parallel data input
clr_status  in  1  pulse: clear counters, health, sticky flags
inj_valid  in  1  fault-injection strobe
inj_sel  in  2  target replica 0..2 (3 = no-op)
inj_mask  in  WIDTH  XOR mask applied to target replica
parallel_out  out  WIDTH  voted register value
serial_out  out  1  voted serial bit
health  out  6  2 bits per replica {r2,r1,r0}: 00 HEALTHY, 01 SUSPECT, 10 FAILED
err_cnt  out  3*ERR_CNT_W  per-replica correction counts {r2,r1,r0}
uncorrectable  out  1  sticky: healthy replicas disagreed with no majority
scrub_active  out  1  high for the one cycle a scrub tick is applied

Behaviour:
- Reset (rst low, any time, mid-operation included): all replicas 0, health all 00, err_cnt 0, uncorrectable 0, scrub counter 0, scrub_active 0.
- Replica next value, computed from base = (replica mismatches vote and not FAILED) ? voted : own value:
  - SISO-R: {serial_in, base[W-1:1]}
  - SISO-L: {base[W-2:0], serial_in}
  - PISO: load ? parallel_in : {0, base[W-1:1]}
  - PIPO: load ? parallel_in : base
  - ROT-R: {base[0], base[W-1:1]}
  - ROT-L: {base[W-2:0], base[W-1]}
  - hold: base
- Update occurs on a clock edge with enable=1. A FAILED replica still updates, but its base is its own value.
- Vote (combinational, zero latency from replica registers):
  - Three non-FAILED replicas: bitwise majority.
  - Two non-FAILED: bitwise AND-agreement check. Output = lower-index healthy replica. Any differing bit sets uncorrectable.
  - One non-FAILED: output = that replica.
- serial_out: vote of per-replica serial bits. A replica's serial bit is bit[0] in modes 0, 2, 4 and bit[W-1] otherwise.
- Mismatch: replica != voted, evaluated only with three non-FAILED replicas. In duplex/simplex, mismatch is never attributed and counters freeze.
- Update event = enable edge or scrub tick.
- Health FSM per replica, evaluated at each update event:
  - HEALTHY -> SUSPECT on mismatch.
  - SUSPECT -> HEALTHY on match.
  - Consecutive-mismatch count reaching FAIL_THRESH -> FAILED.
  - FAILED is absorbing until clr_status.
  - The last non-FAILED replica is never marked FAILED.
  - With FAIL_THRESH=1, a mismatch goes HEALTHY -> FAILED directly.
- err_cnt[i] +1 on each update event where replica i is corrected. Saturates at 2^ERR_CNT_W-1, no wrap.
- Scrub:
  - Counter increments each cycle with enable=0 and resets to 0 when enable=1.
  - At count SCRUB_PERIOD-1: scrub tick. scrub_active=1 that cycle, counter returns to 0.
  - At the tick, mismatching non-FAILED replicas are loaded with voted; other replicas hold.
  - enable=1 in the same cycle suppresses the tick (normal update already corrects).
- Injection: on an edge with inj_valid=1 and inj_sel<3, target replica <= (its normal next value) ^ inj_mask. Other replicas are unaffected.
- clr_status (synchronous) clears health, err_cnt, uncorrectable and consecutive counts. It takes priority over same-cycle FAILED transitions and counter increments; the data update still happens.
- Status outputs are registered: visible the cycle after the causing edge.

Test Plan:
1. PIPO load 0xA5, then inject inj_sel=1 mask=0x0F with mode hold, enable=1 -> parallel_out stays 0xA5; next edge replica 1 corrected; err_cnt r1=1, health r1=01 then 00 after a matching update.
2. Inject replica 2 on 3 consecutive updates (FAIL_THRESH=3) -> health r2=10. Then inject replica 0 mask=0x01 -> uncorrectable=1, parallel_out = replica 0 value.
3. Load 0x81, enable=0 for 16 cycles after injecting replica 0 mask=0xFF -> scrub_active pulses at cycle 16, replica 0 restored to 0x81, err_cnt r0=1.
4. ROT-L from 0x81 for 2 updates -> 0x03 then 0x06; serial_out = bit7 each cycle. SISO-R with serial_in=1 from 0x00 for 8 updates -> 0xFF.
5. Drive 20 corrections on replica 0 (ERR_CNT_W=4) -> err_cnt r0 saturates at 15. Then clr_status -> all status 0, data intact.
6. Assert rst low mid-shift -> all outputs 0 immediately; release, load 0x3C -> 0x3C next edge.
